// File: rtl/aes_mode_stream_ctrl.sv
// Streaming ECB/CBC/CTR wrapper around an external single-block AES-128 core.
// Packs key and plaintext words into 128-bit blocks and serialises results MS-word first.
module aes_mode_stream_ctrl #(
    parameter int WORD_WIDTH = 32,
    parameter int LEN_WIDTH  = 11,
    parameter int CTR_WIDTH  = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [1:0]             mode_i,
    input  logic [LEN_WIDTH-1:0]   len_i,
    input  logic [127:0]           iv_i,
    input  logic                   key_valid_i,
    output logic                   key_ready_o,
    input  logic [WORD_WIDTH-1:0]  key_data_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [WORD_WIDTH-1:0]  in_data_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [WORD_WIDTH-1:0]  out_data_o,
    output logic                   core_valid_o,
    input  logic                   core_ready_i,
    output logic [127:0]           core_block_o,
    output logic [127:0]           core_key_o,
    input  logic                   core_res_valid_i,
    output logic                   core_res_ready_o,
    input  logic [127:0]           core_res_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [LEN_WIDTH-1:0]   blk_cnt_o
);
    localparam int WPB = 128 / WORD_WIDTH;
    localparam int CW  = (WPB > 1) ? $clog2(WPB) : 1;
    localparam logic [CW-1:0]  LAST_WORD = CW'(WPB - 1);
    localparam logic [127:0]   CTR_MASK  = {128{1'b1}} >> (128 - CTR_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_KEY, S_GATHER, S_REQ, S_WAIT, S_EMIT, S_DONE} state_e;
    typedef enum logic [1:0] {M_ECB, M_CBC, M_CTR, M_RSVD} mode_e;

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] blk_cnt_q, blk_cnt_d;
    logic [CW-1:0]        wcnt_q, wcnt_d;
    logic [127:0]         key_q, key_d;
    logic [127:0]         p_q, p_d;
    logic [127:0]         c_q, c_d;
    logic [127:0]         chain_q, chain_d;
    logic [127:0]         ctr_q, ctr_d;

    logic                 word_last;
    logic [LEN_WIDTH-1:0] blk_cnt_inc;
    logic [127:0]         ctr_next;

    assign word_last   = (wcnt_q == LAST_WORD);
    assign blk_cnt_inc = blk_cnt_q + LEN_WIDTH'(1);
    // Only the low CTR_WIDTH bits count; the upper counter bits never see a carry.
    assign ctr_next    = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

    assign out_data_o  = c_q[127 -: WORD_WIDTH];
    assign core_key_o  = key_q;
    assign blk_cnt_o   = blk_cnt_q;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

    always_comb begin
        case (mode_q)
            M_CBC:   core_block_o = p_q ^ chain_q;
            M_CTR:   core_block_o = ctr_q;
            default: core_block_o = p_q;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        len_d            = len_q;
        blk_cnt_d        = blk_cnt_q;
        wcnt_d           = wcnt_q;
        key_d            = key_q;
        p_d              = p_q;
        c_d              = c_q;
        chain_d          = chain_q;
        ctr_d            = ctr_q;
        key_ready_o      = 1'b0;
        in_ready_o       = 1'b0;
        out_valid_o      = 1'b0;
        core_valid_o     = 1'b0;
        core_res_ready_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mode_d    = mode_e'(mode_i);
                    len_d     = len_i;
                    chain_d   = iv_i;
                    ctr_d     = iv_i;
                    blk_cnt_d = '0;
                    wcnt_d    = '0;
                    state_d   = S_KEY;
                end
            end
            S_KEY: begin
                key_ready_o = 1'b1;
                if (key_valid_i) begin
                    key_d  = (key_q << WORD_WIDTH) | 128'(key_data_i);
                    wcnt_d = word_last ? '0 : wcnt_q + CW'(1);
                    if (word_last) state_d = (len_q == '0) ? S_DONE : S_GATHER;
                end
            end
            S_GATHER: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    p_d    = (p_q << WORD_WIDTH) | 128'(in_data_i);
                    wcnt_d = word_last ? '0 : wcnt_q + CW'(1);
                    if (word_last) state_d = S_REQ;
                end
            end
            S_REQ: begin
                core_valid_o = 1'b1;
                if (core_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                core_res_ready_o = 1'b1;
                if (core_res_valid_i) begin
                    case (mode_q)
                        M_CBC: begin
                            c_d     = core_res_i;
                            chain_d = core_res_i;
                        end
                        M_CTR: begin
                            c_d   = core_res_i ^ p_q;
                            ctr_d = ctr_next;
                        end
                        default: c_d = core_res_i;
                    endcase
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    c_d    = c_q << WORD_WIDTH;
                    wcnt_d = word_last ? '0 : wcnt_q + CW'(1);
                    if (word_last) begin
                        blk_cnt_d = blk_cnt_inc;
                        state_d   = (blk_cnt_inc == len_q) ? S_DONE : S_GATHER;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (clear_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            mode_q    <= M_ECB;
            len_q     <= '0;
            blk_cnt_q <= '0;
            wcnt_q    <= '0;
            key_q     <= '0;
            p_q       <= '0;
            c_q       <= '0;
            chain_q   <= '0;
            ctr_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            blk_cnt_q <= blk_cnt_d;
            wcnt_q    <= wcnt_d;
            key_q     <= key_d;
            p_q       <= p_d;
            c_q       <= c_d;
            chain_q   <= chain_d;
            ctr_q     <= ctr_d;
        end
    end
endmodule

// File: tb/tb_aes_mode_stream_ctrl.sv
// Scoreboard bench for aes_mode_stream_ctrl with a behavioural AES-128 core model.
module tb_aes_mode_stream_ctrl;
    localparam logic [127:0] KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1     = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] P2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] P3     = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    localparam logic [127:0] P4     = 128'hf69f2445df4f9b17ad2b417be66c3710;
    localparam logic [127:0] E1     = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] IV_CBC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CBC1   = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] CBC2   = 128'h5086cb9b507219ee95db113a917678b2;
    localparam logic [127:0] CBC3   = 128'h73bed6b8e3c1743b7116e69e22229516;
    localparam logic [127:0] CBC4   = 128'h3ff1caa1681fac09120eca307586e1a7;
    localparam logic [127:0] IV_CTR = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [127:0] CTR1   = 128'h874d6191b620e3261bef6864990db6ce;
    localparam logic [127:0] CTR2   = 128'h9806f66b7970fdff8617187bb9fffdff;
    localparam logic [127:0] IV_WRP = 128'h00112233445566778899aabbffffffff;

    logic clk = 1'b0, rst = 1'b1, clr = 1'b0, start = 1'b0;
    logic [1:0]   mode = '0;
    logic [10:0]  len  = '0;
    logic [127:0] iv   = '0;
    logic key_valid = 1'b0, key_ready, in_valid = 1'b0, in_ready;
    logic [31:0]  key_data = '0, in_data = '0, out_data;
    logic out_valid, out_ready = 1'b1, core_valid, core_ready = 1'b1;
    logic core_res_valid = 1'b0, core_res_ready, busy, done;
    logic [127:0] core_block, core_key, core_res = '0;
    logic [10:0]  blk_cnt;

    logic w_start = 1'b0, w_key_valid = 1'b0, w_key_ready, w_in_valid = 1'b0, w_in_ready;
    logic [127:0] w_key_data = '0, w_in_data = '0, w_out_data, w_core_block, w_core_key, w_core_res = '0;
    logic w_out_valid, w_out_ready = 1'b0, w_core_valid, w_core_ready = 1'b1;
    logic w_core_res_valid = 1'b0, w_core_res_ready, w_busy, w_done;
    logic [10:0]  w_blk_cnt;

    int tests_run = 0, tests_failed = 0, done_cnt = 0;
    bit rand_rdy = 1'b0, hold_rdy = 1'b0;
    logic [127:0] cur_key = KEY;
    logic [31:0]  exp_out_q[$];
    logic [127:0] exp_blk_q[$];
    logic [31:0]  mon_w;
    logic [7:0]   sbox [256];

    aes_mode_stream_ctrl #(.WORD_WIDTH(32), .LEN_WIDTH(11), .CTR_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start), .mode_i(mode), .len_i(len), .iv_i(iv),
        .key_valid_i(key_valid), .key_ready_o(key_ready), .key_data_i(key_data),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .core_valid_o(core_valid), .core_ready_i(core_ready), .core_block_o(core_block), .core_key_o(core_key),
        .core_res_valid_i(core_res_valid), .core_res_ready_o(core_res_ready), .core_res_i(core_res),
        .busy_o(busy), .done_o(done), .blk_cnt_o(blk_cnt));

    aes_mode_stream_ctrl #(.WORD_WIDTH(128), .LEN_WIDTH(11), .CTR_WIDTH(32)) dut128 (
        .clk_i(clk), .rst_i(rst), .clear_i(1'b0), .start_i(w_start), .mode_i(2'd0), .len_i(11'd1), .iv_i(128'd0),
        .key_valid_i(w_key_valid), .key_ready_o(w_key_ready), .key_data_i(w_key_data),
        .in_valid_i(w_in_valid), .in_ready_o(w_in_ready), .in_data_i(w_in_data),
        .out_valid_o(w_out_valid), .out_ready_i(w_out_ready), .out_data_o(w_out_data),
        .core_valid_o(w_core_valid), .core_ready_i(w_core_ready), .core_block_o(w_core_block), .core_key_o(w_core_key),
        .core_res_valid_i(w_core_res_valid), .core_res_ready_o(w_core_res_ready), .core_res_i(w_core_res),
        .busy_o(w_busy), .done_o(w_done), .blk_cnt_o(w_blk_cnt));

    always #5 clk = ~clk;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box derived from the GF(2^8) inverse (x^254) plus the affine map.
    function automatic logic [7:0] sbox_calc(input int i);
        logic [7:0] v = 8'h01, b;
        for (int k = 0; k < 254; k++) v = gmul(v, 8'(i));
        b = v;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0] w [176];
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] tmp [4];
        logic [7:0] rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                a0 = tmp[0];
                tmp[0] = sbox[tmp[1]] ^ rc;
                tmp[1] = sbox[tmp[2]];
                tmp[2] = sbox[tmp[3]];
                tmp[3] = sbox[a0];
                rc = xt(rc);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] ^= w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = hold_rdy ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Output scoreboard and done-pulse counter.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (out_valid && out_ready) begin
            tests_run++;
            if (exp_out_q.size() == 0) begin
                tests_failed++;
                $display("FAIL out_extra got %h exp no word", out_data);
            end else begin
                mon_w = exp_out_q.pop_front();
                if (out_data !== mon_w) begin
                    tests_failed++;
                    $display("FAIL out_word got %h exp %h", out_data, mon_w);
                end
            end
        end
    end

    always begin : core_model
        int n;
        logic [127:0] r, e;
        @(negedge clk);
        if (core_valid && core_ready) begin
            if (exp_blk_q.size() > 0) begin
                e = exp_blk_q.pop_front();
                tests_run++;
                if (core_block !== e) begin
                    tests_failed++;
                    $display("FAIL core_block got %h exp %h", core_block, e);
                end
            end
            tests_run++;
            if (core_key !== cur_key) begin
                tests_failed++;
                $display("FAIL core_key got %h exp %h", core_key, cur_key);
            end
            r = aes_enc(cur_key, core_block);
            @(negedge clk);
            core_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            core_res = r;
            core_res_valid = 1'b1;
            n = 0;
            while (!core_res_ready && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
            core_res_valid = 1'b0;
            core_ready = 1'b1;
        end
    end

    task automatic push_out(input logic [127:0] c);
        for (int i = 0; i < 4; i++) exp_out_q.push_back(c[127-32*i -: 32]);
    endtask

    task automatic send_words(input bit is_key, input logic [127:0] v, output bit ok);
        int n;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (is_key) begin key_valid = 1'b1; key_data = v[127-32*i -: 32]; end
            else begin in_valid = 1'b1; in_data = v[127-32*i -: 32]; end
            n = 0;
            while (!(is_key ? key_ready : in_ready) && n < 500) begin @(negedge clk); n++; end
            if (n >= 500) ok = 1'b0;
            @(negedge clk);
        end
        key_valid = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic run_job(input logic [1:0] m, input int nblk, input logic [127:0] v,
                           input logic [511:0] pts, output bit ok, output int ndone);
        bit s_ok;
        int d0, n;
        d0 = done_cnt;
        start = 1'b1; mode = m; len = 11'(nblk); iv = v;
        @(negedge clk);
        start = 1'b0;
        send_words(1'b1, cur_key, ok);
        for (int b = 0; b < nblk; b++) begin
            send_words(1'b0, pts[511-128*b -: 128], s_ok);
            ok &= s_ok;
        end
        n = 0;
        while (done_cnt == d0 && n < 3000) begin @(negedge clk); n++; end
        if (done_cnt == d0) ok = 1'b0;
        repeat (3) @(negedge clk);
        ndone = done_cnt - d0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({key_ready, in_ready, out_valid, core_valid, core_res_ready, busy, done} !== 7'b0) begin
            tests_failed++; $display("FAIL reset_ctrl got %b exp 0000000",
                {key_ready, in_ready, out_valid, core_valid, core_res_ready, busy, done});
        end
        tests_run++;
        if ({out_data, blk_cnt, core_block, core_key} !== '0) begin
            tests_failed++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", out_data, blk_cnt, core_block, core_key);
        end
        tests_run++;
        if ({w_key_ready, w_in_ready, w_out_valid, w_core_valid, w_busy, w_done} !== 6'b0 || w_out_data !== '0) begin
            tests_failed++; $display("FAIL reset_w128 got %b/%h exp 0",
                {w_key_ready, w_in_ready, w_out_valid, w_core_valid, w_busy, w_done}, w_out_data);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single(input string nm, input logic [1:0] m, input logic [127:0] v,
                               input logic [127:0] eblk, input logic [127:0] eout);
        bit ok;
        int nd;
        exp_blk_q.push_back(eblk);
        push_out(eout);
        run_job(m, 1, v, {P1, 384'd0}, ok, nd);
        tests_run++;
        if (!ok || nd != 1 || blk_cnt !== 11'd1) begin
            tests_failed++; $display("FAIL %s_end got ok=%0d done=%0d blk=%0d exp 1/1/1", nm, ok, nd, blk_cnt);
        end
        tests_run++;
        if (exp_out_q.size() != 0 || exp_blk_q.size() != 0) begin
            tests_failed++; $display("FAIL %s_drain got %0d/%0d exp 0/0", nm, exp_out_q.size(), exp_blk_q.size());
        end
    endtask

    task automatic test_cbc_multi();
        bit ok;
        int nd;
        exp_blk_q.push_back(P1 ^ IV_CBC);
        exp_blk_q.push_back(P2 ^ CBC1);
        exp_blk_q.push_back(P3 ^ CBC2);
        exp_blk_q.push_back(P4 ^ CBC3);
        push_out(CBC1); push_out(CBC2); push_out(CBC3); push_out(CBC4);
        rand_rdy = 1'b1;
        fork
            run_job(2'd1, 4, IV_CBC, {P1, P2, P3, P4}, ok, nd);
            begin
                repeat (30) @(negedge clk);
                start = 1'b1; mode = 2'd0; len = 11'd1; iv = '0;
                @(negedge clk);
                start = 1'b0;
            end
        join
        rand_rdy = 1'b0;
        tests_run++;
        if (!ok || nd != 1 || blk_cnt !== 11'd4) begin
            tests_failed++; $display("FAIL cbc4_end got ok=%0d done=%0d blk=%0d exp 1/1/4", ok, nd, blk_cnt);
        end
        tests_run++;
        if (exp_out_q.size() != 0 || exp_blk_q.size() != 0) begin
            tests_failed++; $display("FAIL cbc4_drain got %0d/%0d exp 0/0", exp_out_q.size(), exp_blk_q.size());
        end
    endtask

    task automatic test_ctr(input string nm, input logic [127:0] v, input logic [127:0] blk2,
                            input logic [127:0] c1, input logic [127:0] c2);
        bit ok;
        int nd;
        exp_blk_q.push_back(v);
        exp_blk_q.push_back(blk2);
        push_out(c1);
        push_out(c2);
        run_job(2'd2, 2, v, {P1, P2, 256'd0}, ok, nd);
        tests_run++;
        if (!ok || nd != 1 || blk_cnt !== 11'd2) begin
            tests_failed++; $display("FAIL %s_end got ok=%0d done=%0d blk=%0d exp 1/1/2", nm, ok, nd, blk_cnt);
        end
        tests_run++;
        if (exp_out_q.size() != 0 || exp_blk_q.size() != 0) begin
            tests_failed++; $display("FAIL %s_drain got %0d/%0d exp 0/0", nm, exp_out_q.size(), exp_blk_q.size());
        end
    endtask

    task automatic test_len0();
        bit ok;
        int nd;
        run_job(2'd2, 0, IV_CTR, '0, ok, nd);
        tests_run++;
        if (!ok || nd != 1 || blk_cnt !== 11'd0) begin
            tests_failed++; $display("FAIL len0 got ok=%0d done=%0d blk=%0d exp 1/1/0", ok, nd, blk_cnt);
        end
    endtask

    task automatic test_clear_wait();
        bit ok;
        int n, d0;
        exp_blk_q.push_back(P1);
        start = 1'b1; mode = 2'd0; len = 11'd1; iv = '0;
        @(negedge clk);
        start = 1'b0;
        send_words(1'b1, cur_key, ok);
        send_words(1'b0, P1, ok);
        n = 0;
        while (!core_res_ready && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (!core_res_ready) begin tests_failed++; $display("FAIL clear_reach_wait got 0 exp 1"); end
        d0 = done_cnt;
        clr = 1'b1; start = 1'b1;
        @(negedge clk);
        clr = 1'b0; start = 1'b0;
        tests_run++;
        if ({busy, out_valid, core_res_ready, done} !== 4'b0) begin
            tests_failed++; $display("FAIL clear_idle got %b exp 0000", {busy, out_valid, core_res_ready, done});
        end
        repeat (30) @(negedge clk);
        tests_run++;
        if (done_cnt != d0 || busy !== 1'b0 || exp_blk_q.size() != 0) begin
            tests_failed++; $display("FAIL clear_quiet got done=%0d busy=%b exp 0/0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_rst_emit();
        bit ok;
        int n;
        hold_rdy = 1'b1;
        exp_blk_q.push_back(P1);
        start = 1'b1; mode = 2'd0; len = 11'd1; iv = '0;
        @(negedge clk);
        start = 1'b0;
        send_words(1'b1, cur_key, ok);
        send_words(1'b0, P1, ok);
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== E1[127:96]) begin
            tests_failed++; $display("FAIL rst_reach_emit got %b/%h exp 1/%h", out_valid, out_data, E1[127:96]);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({key_ready, in_ready, out_valid, core_valid, core_res_ready, busy, done} !== 7'b0 ||
            {out_data, blk_cnt, core_block, core_key} !== '0) begin
            tests_failed++; $display("FAIL rst_emit got %b/%h/%h/%h exp 0",
                {key_ready, in_ready, out_valid, core_valid, core_res_ready, busy, done}, out_data, blk_cnt, core_key);
        end
        rst = 1'b0;
        hold_rdy = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_w128();
        w_start = 1'b1;
        @(negedge clk);
        w_start = 1'b0;
        w_key_valid = 1'b1; w_key_data = KEY;
        tests_run++;
        if (w_key_ready !== 1'b1) begin tests_failed++; $display("FAIL w128_key_ready got %b exp 1", w_key_ready); end
        @(negedge clk);
        w_key_valid = 1'b0;
        w_in_valid = 1'b1; w_in_data = P1;
        tests_run++;
        if ({w_key_ready, w_in_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL w128_one_key_beat got %b exp 01", {w_key_ready, w_in_ready});
        end
        @(negedge clk);
        w_in_valid = 1'b0;
        tests_run++;
        if ({w_in_ready, w_core_valid} !== 2'b01 || w_core_block !== P1 || w_core_key !== KEY) begin
            tests_failed++; $display("FAIL w128_req got %b/%h exp 01/%h", {w_in_ready, w_core_valid}, w_core_block, P1);
        end
        @(negedge clk);
        w_core_res = aes_enc(KEY, P1);
        w_core_res_valid = 1'b1;
        tests_run++;
        if (w_core_res_ready !== 1'b1) begin tests_failed++; $display("FAIL w128_wait got %b exp 1", w_core_res_ready); end
        @(negedge clk);
        w_core_res_valid = 1'b0;
        tests_run++;
        if (w_out_valid !== 1'b1 || w_out_data !== E1) begin
            tests_failed++; $display("FAIL w128_out got %b/%h exp 1/%h", w_out_valid, w_out_data, E1);
        end
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        tests_run++;
        if (w_out_valid !== 1'b0 || w_done !== 1'b1 || w_blk_cnt !== 11'd1) begin
            tests_failed++; $display("FAIL w128_done got %b/%b/%0d exp 0/1/1", w_out_valid, w_done, w_blk_cnt);
        end
        @(negedge clk);
        tests_run++;
        if ({w_busy, w_done} !== 2'b00) begin tests_failed++; $display("FAIL w128_idle got %b exp 00", {w_busy, w_done}); end
    endtask

    initial begin : main
        logic [127:0] wrap2;
        for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(i);
        wrap2 = IV_WRP;
        wrap2[31:0] = 32'h0;
        @(negedge clk);
        test_reset();
        test_single("ecb", 2'd0, '0, P1, E1);
        test_single("cbc", 2'd1, IV_CBC, 128'h6bc0bce12a459991e134741a7f9e1925, CBC1);
        test_cbc_multi();
        test_ctr("ctr", IV_CTR, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00, CTR1, CTR2);
        test_ctr("ctr_wrap", IV_WRP, wrap2, aes_enc(KEY, IV_WRP) ^ P1, aes_enc(KEY, wrap2) ^ P2);
        test_len0();
        test_clear_wait();
        test_rst_emit();
        test_w128();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "simulation time limit");
    end
endmodule
